sound_att_mixer: RTL and testbench
==================================

// Module: sound_att_mixer
// PURPOSE
//  Runtime-programmable, multi-channel successor to the fixed build-time MUL/DIV attenuators.
//  Mixes NUM_CH signed sound sources (PSG, FM, SCC, MEGAROM, ...) into a stereo pair.
//  Each channel has a programmable gain mul/2^DIV_SHIFT, a mute bit and L/R pan enables.
//  One time-shared multiplier runs one channel per clock; sits between the generators and the DAC/PWM stage.
// PARAMETERS
//  NUM_CH     4   number of input channels (1..16)
//  IN_W       10  input sample width, signed (= SOUND_BIT_WIDTH)
//  OUT_W      12  output sample width, signed, saturated
//  MUL_W      4   gain numerator width, unsigned
//  DIV_SHIFT  2   gain denominator = 2^DIV_SHIFT (reset gain 4/4 = unity)
// PORTS
//  clk        in   1             system clock
//  reset      in   1             synchronous, active-high reset
//  smp_stb    in   1             new-sample strobe, 1-cycle pulse
//  smp_in     in   NUM_CH*IN_W   channel samples, ch0 in LSBs, two's complement
//  cfg_we     in   1             config write enable
//  cfg_ch     in   $clog2(NUM_CH) config target channel (values >= NUM_CH ignored)
//  cfg_mul    in   MUL_W         gain numerator
//  cfg_mute   in   1             1 = channel contributes 0
//  cfg_pan    in   2             {L_en, R_en}
//  out_l      out  OUT_W         left mix, signed
//  out_r      out  OUT_W         right mix, signed
//  out_valid  out  1             1-cycle pulse when out_l/out_r update
//  busy       out  1             mix in progress
//  overrun    out  1             1-cycle pulse: smp_stb dropped while busy
// BEHAVIOUR
//  Reset: out_l = out_r = 0; out_valid = busy = overrun = 0; FSM = IDLE.
//   All channels: mul = 2^DIV_SHIFT, mute = 0, pan = 2'b11.
//  FSM states:
//   IDLE --smp_stb--> ACC (cycle T): latch all smp_in; clear acc_l/acc_r; ch = 0; busy = 1.
//   ACC: one channel per cycle, T+1 .. T+NUM_CH.
//    prod = $signed(in[ch]) * $signed({1'b0, mul[ch]}); width IN_W+MUL_W+1.
//    If !mute: acc_l += prod when L_en; acc_r += prod when R_en.
//    acc width = IN_W + MUL_W + 1 + $clog2(NUM_CH) + 1; no overflow is possible.
//    After ch = NUM_CH-1 -> OUT.
//   OUT (cycle T+NUM_CH+1):
//    out_x = sat_OUT_W(acc_x >>> DIV_SHIFT); arithmetic shift, floor toward -inf.
//    Saturation clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//    out_valid = 1; busy = 0; -> IDLE.
//  Latency: smp_stb to out_valid = NUM_CH+1 cycles.
//   Minimum strobe spacing = NUM_CH+2 cycles.
//   out_l/out_r hold their value between out_valid pulses.
//  smp_stb while busy (ACC or OUT): strobe ignored, overrun pulses the next cycle, current mix unaffected.
//   smp_stb on the cycle OUT -> IDLE is also ignored.
//  Config writes are accepted in any state and registered at the clock edge.
//   A write to the channel processed in the same cycle uses the old value; the new value applies from the next mix.
//   A write to a channel already processed in the current mix applies from the next mix.
//   A write to a not-yet-processed channel applies in the current mix.
//  cfg_ch >= NUM_CH: write dropped, no side effect.
//  Reset mid-mix: mix aborted, no out_valid, all state and config return to reset values.
// TESTING
//  1 After reset: ch0 = 100, others 0, strobe
//    -> out_valid at T+5; out_l = out_r = 100.
//  2 cfg ch0 mul = 9; ch0 = 100; strobe
//    -> out_l = out_r = 225 (900>>>2).
//    ch0 = -3, mul = 1 -> out = -1 (floor).
//  3 All 4 ch = 511, mul = 9 -> out = +2047 (saturated).
//    All ch = -512, mul = 15 -> out = -2048.
//  4 ch1 pan = 2'b10, ch2 mute, ch0..2 = 40
//    -> out_l = 80, out_r = 40.
//  5 smp_stb at T and T+2
//    -> overrun pulse at T+3; single out_valid at T+5 reflecting the T samples.
//    Strobe at T+6 -> accepted.
//  6 reset asserted at T+3 of a mix
//    -> no out_valid; outputs 0.
//    Next strobe mixes with unity gain, pan 2'b11.

Source files
------------

// File: rtl/sound_att_mixer.sv
// sound_att_mixer: multi-channel stereo mixer with runtime-programmable gain,
// mute and L/R pan for each channel. The block has one time-shared
// multiplier, so it processes one channel per clock. The result is
// arithmetic-shifted by DIV_SHIFT and then saturated to OUT_W bits.
module sound_att_mixer #(
  parameter  int NUM_CH    = 4,
  parameter  int IN_W      = 10,
  parameter  int OUT_W     = 12,
  parameter  int MUL_W     = 4,
  parameter  int DIV_SHIFT = 2,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     smp_stb,
  input  logic [NUM_CH*IN_W-1:0]   smp_in,
  input  logic                     cfg_we,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [MUL_W-1:0]         cfg_mul,
  input  logic                     cfg_mute,
  input  logic [1:0]               cfg_pan,
  output logic signed [OUT_W-1:0]  out_l,
  output logic signed [OUT_W-1:0]  out_r,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam int PROD_W = IN_W + MUL_W + 1;
  // Headroom covers the sum of NUM_CH worst-case products, so the accumulator cannot wrap.
  localparam int ACC_W  = PROD_W + $clog2(NUM_CH) + 1;

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;
  localparam logic [MUL_W-1:0]        UNITY  = MUL_W'(2 ** DIV_SHIFT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_OUT
  } state_e;

  state_e                    state_q;
  logic [CH_W-1:0]           ch_q;
  logic signed [IN_W-1:0]    smp_q  [NUM_CH];
  logic [MUL_W-1:0]          mul_q  [NUM_CH];
  logic                      mute_q [NUM_CH];
  logic [1:0]                pan_q  [NUM_CH];
  logic signed [ACC_W-1:0]   acc_l_q, acc_r_q;
  logic signed [OUT_W-1:0]   out_l_q, out_r_q;
  logic                      out_valid_q, busy_q, overrun_q;

  logic signed [PROD_W-1:0]  smp_ext, gain_ext, prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   acc_l_d, acc_r_d;
  logic signed [ACC_W-1:0]   sh_l, sh_r;

  // Clamp a shifted accumulator value to the signed OUT_W output range.
  function automatic logic signed [OUT_W-1:0] sat(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] c;
    if (v > SAT_HI)      c = SAT_HI;
    else if (v < SAT_LO) c = SAT_LO;
    else                 c = v;
    return c[OUT_W-1:0];
  endfunction

  // Compute the product for the current channel and the next accumulator values.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    smp_ext  = PROD_W'(smp_q[ch_q]);
    gain_ext = PROD_W'($signed({1'b0, mul_q[ch_q]}));
    prod     = smp_ext * gain_ext;
    prod_ext = ACC_W'(prod);
    acc_l_d  = acc_l_q;
    acc_r_d  = acc_r_q;
    if (!mute_q[ch_q]) begin
      if (pan_q[ch_q][1]) acc_l_d = acc_l_q + prod_ext;
      if (pan_q[ch_q][0]) acc_r_d = acc_r_q + prod_ext;
    end
    sh_l = acc_l_d >>> DIV_SHIFT;
    sh_r = acc_r_d >>> DIV_SHIFT;
  end

  // Mix FSM, config register file and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
    if (reset) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      out_l_q     <= '0;
      out_r_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      // NOTE: these small arrays are reset because the reset gain, mute and pan values are visible behaviour, not scratch data.
      for (int i = 0; i < NUM_CH; i++) begin
        smp_q[i]  <= '0;
        mul_q[i]  <= UNITY;
        mute_q[i] <= 1'b0;
        pan_q[i]  <= 2'b11;
      end
    end else begin
      out_valid_q <= 1'b0;
      overrun_q   <= smp_stb && (state_q != S_IDLE);

      // The datapath reads the old value this cycle; the new value applies from the next channel visit.
      if (cfg_we && (32'(cfg_ch) < NUM_CH)) begin
        mul_q[cfg_ch]  <= cfg_mul;
        mute_q[cfg_ch] <= cfg_mute;
        pan_q[cfg_ch]  <= cfg_pan;
      end

      case (state_q)
        S_IDLE: begin
          if (smp_stb) begin
            for (int i = 0; i < NUM_CH; i++) smp_q[i] <= smp_in[i*IN_W +: IN_W];
            acc_l_q <= '0;
            acc_r_q <= '0;
            ch_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= S_ACC;
          end
        end
        S_ACC: begin
          acc_l_q <= acc_l_d;
          acc_r_q <= acc_r_d;
          if (32'(ch_q) == NUM_CH - 1) begin
            // The result is registered on the last accumulate edge, so out_valid is high during OUT.
            out_l_q     <= sat(sh_l);
            out_r_q     <= sat(sh_r);
            out_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end else begin
            ch_q <= ch_q + 1'b1;
          end
        end
        S_OUT: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_l     = out_l_q;
  assign out_r     = out_r_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sound_att_mixer.sv
// Testbench for sound_att_mixer. Directed stimulus pushes the expected stereo
// result and its due cycle into a scoreboard. A monitor pops an entry and
// compares it each time out_valid is high.
module tb_sound_att_mixer;

  localparam int NUM_CH = 4;

  logic               clk = 1'b0;
  logic               reset, smp_stb, cfg_we, cfg_mute;
  logic [39:0]        smp_in;
  logic [1:0]         cfg_ch, cfg_pan;
  logic [3:0]         cfg_mul;
  logic signed [11:0] out_l, out_r;
  logic               out_valid, busy, overrun;

  typedef struct {
    int l;
    int r;
    int due;
  } exp_t;

  exp_t sb_q[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  sound_att_mixer dut (
    .clk      (clk),
    .reset    (reset),
    .smp_stb  (smp_stb),
    .smp_in   (smp_in),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_mul  (cfg_mul),
    .cfg_mute (cfg_mute),
    .cfg_pan  (cfg_pan),
    .out_l    (out_l),
    .out_r    (out_r),
    .out_valid(out_valid),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  // Count rising edges so latency can be checked in cycles.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every out_valid pulse against the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("mix_l", out_l, e.l);
        check("mix_r", out_r, e.r);
        check("latency", cyc, e.due);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_smp(input int a, input int b, input int c, input int d);
    smp_in = {d[9:0], c[9:0], b[9:0], a[9:0]};
  endtask

  task automatic cfg(input int ch, input int mul, input bit mute, input logic [1:0] pan);
    cfg_we   = 1'b1;
    cfg_ch   = ch[1:0];
    cfg_mul  = mul[3:0];
    cfg_mute = mute;
    cfg_pan  = pan;
    tick();
    cfg_we   = 1'b0;
  endtask

  // Raise the strobe for one cycle. If expect_out is set, push the result,
  // which should appear NUM_CH+1 cycles later.
  task automatic strobe(input int el, input int er, input bit expect_out);
    exp_t e;
    smp_stb = 1'b1;
    if (expect_out) begin
      e.l   = el;
      e.r   = er;
      e.due = cyc + NUM_CH + 1;
      sb_q.push_back(e);
    end
    tick();
    smp_stb = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) tick();
    check("drain", sb_q.size(), 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    smp_stb  = 1'b0;
    cfg_we   = 1'b0;
    cfg_ch   = '0;
    cfg_mul  = '0;
    cfg_mute = 1'b0;
    cfg_pan  = 2'b00;
    smp_in   = '0;
    repeat (3) tick();
    check("rst_out_l", out_l, 0);
    check("rst_out_r", out_r, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b0;
    tick();

    // 1: unity gain after reset.
    set_smp(100, 0, 0, 0);
    strobe(100, 100, 1'b1);
    check("busy_in_acc", busy, 1);
    drain();

    // 2: gain 9/4, then floor of a negative value.
    cfg(0, 9, 1'b0, 2'b11);
    set_smp(100, 0, 0, 0);
    strobe(225, 225, 1'b1);
    drain();
    cfg(0, 1, 1'b0, 2'b11);
    set_smp(-3, 0, 0, 0);
    strobe(-1, -1, 1'b1);
    drain();
    repeat (3) tick();
    check("hold_l", out_l, -1);
    check("hold_valid", out_valid, 0);

    // 3: positive and negative saturation.
    for (int c = 0; c < 4; c++) cfg(c, 9, 1'b0, 2'b11);
    set_smp(511, 511, 511, 511);
    strobe(2047, 2047, 1'b1);
    drain();
    for (int c = 0; c < 4; c++) cfg(c, 15, 1'b0, 2'b11);
    set_smp(-512, -512, -512, -512);
    strobe(-2048, -2048, 1'b1);
    drain();

    // 4: pan and mute.
    cfg(0, 4, 1'b0, 2'b11);
    cfg(1, 4, 1'b0, 2'b10);
    cfg(2, 4, 1'b1, 2'b11);
    cfg(3, 4, 1'b0, 2'b11);
    set_smp(40, 40, 40, 0);
    strobe(80, 40, 1'b1);
    drain();

    // Config writes during a mix. ch0 is written while it is processed, so
    // the old gain applies. ch3 is written before it is reached, so the new
    // gain applies. 40*4 + 40*8 = 480, and 480>>>2 = 120.
    cfg(1, 4, 1'b0, 2'b11);
    cfg(2, 4, 1'b0, 2'b11);
    set_smp(40, 0, 0, 40);
    strobe(120, 120, 1'b1);
    cfg(0, 8, 1'b0, 2'b11);
    cfg(3, 8, 1'b0, 2'b11);
    drain();
    strobe(160, 160, 1'b1);
    drain();

    // 5: a strobe during a busy mix is dropped and overrun pulses.
    cfg(0, 4, 1'b0, 2'b11);
    cfg(3, 4, 1'b0, 2'b11);
    set_smp(10, 0, 0, 0);
    strobe(10, 10, 1'b1);           // cycle T, now in T+1
    tick();                         // now in T+2
    set_smp(50, 0, 0, 0);
    smp_stb = 1'b1;
    tick();                         // now in T+3
    smp_stb = 1'b0;
    check("overrun_pulse", overrun, 1);
    tick();                         // T+4
    check("overrun_clear", overrun, 0);
    tick();                         // T+5, OUT
    check("busy_in_out", busy, 1);
    tick();                         // T+6, IDLE
    check("busy_idle", busy, 0);
    strobe(50, 50, 1'b1);
    drain();

    // 6: reset in the middle of a mix aborts it and restores the config.
    cfg(0, 8, 1'b0, 2'b01);
    set_smp(100, 0, 0, 0);
    strobe(0, 0, 1'b0);             // now in T+1
    tick();                         // T+2
    tick();                         // T+3
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_out_l", out_l, 0);
    check("abort_out_r", out_r, 0);
    check("abort_busy", busy, 0);
    repeat (8) tick();
    strobe(100, 100, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
